// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Time-shares one external combinational ALU between two requesters.
// Requests arrive on valid/ready channels and are arbitrated round-robin.
// The winner's operands are registered and drive the ALU for one EXEC cycle.
// The ALU output is then captured and returned on the winner's response
// channel, where it is held until the requester takes it.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready       request handshake per requester
//   req{0,1}_a/_b/_ctrl         operands and ALU opcode per requester
//   rsp{0,1}_valid/_ready       response handshake per requester
//   rsp_result, rsp_zero        captured ALU result/zero (shared by both)
//   alu_a, alu_b, alu_ctrl      operands steered to the external ALU
//   alu_result, alu_zero        external ALU outputs
//   busy                        high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic               last_grant_reg;
  logic               owner_reg;
  logic [WIDTH-1:0]   op_a_reg, op_b_reg;
  logic [CTRL_W-1:0]  op_ctrl_reg;
  logic [1:0]         rsp_valid_reg;
  logic [WIDTH-1:0]   rsp_result_reg;
  logic               rsp_zero_reg;

  logic [1:0]         rsp_ready_vec;
  logic [1:0]         rsp_hs_vec;
  logic               rsp_hs;
  logic               accept_window;
  logic               grant0, grant1;
  logic               accept;
  logic               grant_id;

  // Only the owner's valid bit is ever set, so OR-ing the per-channel
  // handshakes gives the handshake of the current response.
  assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_hs
      assign rsp_hs_vec[gi] = rsp_valid_reg[gi] & rsp_ready_vec[gi];
    end
  endgenerate

  assign rsp_hs = (state_reg == RESP) & (|rsp_hs_vec);

  // A new operation may start when idle, or when the pending response
  // retires this very cycle (gives one op per two cycles back-to-back).
  assign accept_window = (state_reg == IDLE) | rsp_hs;

  // Round-robin: on contention the requester that did not win last time
  // gets the grant. last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (accept_window) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_reg;
        grant1 = ~last_grant_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign grant_id   = grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_hs) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_ctrl_reg    <= '0;
      rsp_valid_reg  <= 2'b00;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      // Operands are sampled only on accept, so they stay stable on the
      // ALU from EXEC through the whole RESP phase.
      if (accept) begin
        op_a_reg       <= grant_id ? req1_a    : req0_a;
        op_b_reg       <= grant_id ? req1_b    : req0_b;
        op_ctrl_reg    <= grant_id ? req1_ctrl : req0_ctrl;
        owner_reg      <= grant_id;
        last_grant_reg <= grant_id;
      end
      if (state_reg == EXEC) begin
        rsp_result_reg <= alu_result;
        rsp_zero_reg   <= alu_zero;
        rsp_valid_reg  <= owner_reg ? 2'b10 : 2'b01;
      end else if (rsp_hs) begin
        rsp_valid_reg  <= 2'b00;
      end
    end
  end

  assign alu_a      = op_a_reg;
  assign alu_b      = op_b_reg;
  assign alu_ctrl   = op_ctrl_reg;
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Drives the arbiter with directed scenarios followed by random traffic,
// supplies the external ALU, and compares every DUT output each cycle with
// a transaction-level model (one outstanding operation, its age, the last
// winner). Expected results come from the requested operands at accept.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU seen by the DUT.
  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Transaction-level model state.
  bit          m_have;     // an operation is in flight
  int          m_age;      // 0 = executing, 1 = response offered
  int          m_owner;
  int          m_last;     // previous winner
  logic [31:0] m_a, m_b;
  logic [3:0]  m_ctrl;
  logic [31:0] m_op_res, m_res;
  bit          m_op_zero, m_zero;
  bit          g0, g1;     // grants observed in the last step

  task automatic reset_model();
    m_have = 0; m_age = 0; m_owner = 0; m_last = 1;
    m_a = 0; m_b = 0; m_ctrl = 0;
    m_op_res = 0; m_res = 0; m_op_zero = 0; m_zero = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it so the caller can drive inputs.
  task automatic step();
    bit pend, hs, win, e0, e1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    @(negedge clk);
    pend = m_have && (m_age >= 1);
    hs   = pend && ((m_owner == 0) ? rsp0_ready : rsp1_ready);
    win  = !m_have || hs;
    e0 = 0; e1 = 0;
    if (win) begin
      if (req0_valid && req1_valid) begin
        if (m_last == 1) e0 = 1; else e1 = 1;
      end else if (req0_valid) e0 = 1;
      else if (req1_valid) e1 = 1;
    end
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp0_valid", rsp0_valid, pend && m_owner == 0);
    chk("rsp1_valid", rsp1_valid, pend && m_owner == 1);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero",   rsp_zero,   m_zero);
    chk("busy",       busy,       m_have);
    chk("alu_a",      alu_a,      m_a);
    chk("alu_b",      alu_b,      m_b);
    chk("alu_ctrl",   alu_ctrl,   m_ctrl);
    a0 = req0_a; b0 = req0_b; c0 = req0_ctrl;
    a1 = req1_a; b1 = req1_b; c1 = req1_ctrl;
    g0 = e0; g1 = e1;
    @(posedge clk);
    if (m_have && m_age == 0) begin
      m_res = m_op_res; m_zero = m_op_zero; m_age = 1;
    end else if (hs) begin
      $display("txn rsp%0d result=%08h zero=%0d", m_owner, m_res, m_zero);
      m_have = 0;
    end
    if (e0 || e1) begin
      m_have = 1; m_age = 0;
      m_owner = e1 ? 1 : 0;
      m_last  = m_owner;
      m_a    = e1 ? a1 : a0;
      m_b    = e1 ? b1 : b0;
      m_ctrl = e1 ? c1 : c0;
      m_op_res  = ref_alu(m_a, m_b, m_ctrl);
      m_op_zero = (m_op_res == 32'd0);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    g0 = 0; g1 = 0;
    do_reset();

    // Reset values.
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);

    // req0 ADD 5+7.
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_ctrl = 0; rsp0_ready = 1;
    #1 chk("add_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    #1 chk("add_exec_valid", rsp0_valid, 0);
    step();
    chk("add_rsp_valid", rsp0_valid, 1);
    chk("add_result", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_rsp1_valid", rsp1_valid, 0);
    step();

    // Contention: SUB 9,9 vs SLTU 1,2, strict alternation over 6 ops.
    do_reset();
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_ctrl = 1;
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_ctrl = 9;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i % 2 == 0) chk("rr_grant0", req0_ready, ((i / 2) % 2) == 0);
      if (i >= 2 && i % 2 == 0)
        chk("rr_result", rsp_result, ((((i / 2) - 1) % 2) == 0) ? 32'd0 : 32'd1);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    #1 chk("rr_last_valid", rsp1_valid, 1);
    step();

    // Backpressure: req1 SRA 0x80000000 >>> 4 held 5 cycles, req0 waits.
    req1_valid = 1; req1_a = 32'h8000_0000; req1_b = 4; req1_ctrl = 7;
    rsp1_ready = 0;
    #1 chk("bp_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = 0; rsp0_ready = 1;
    #1 chk("bp_exec_req0_ready", req0_ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_result", rsp_result, 32'hF800_0000);
      chk("bp_busy", busy, 1);
      chk("bp_req0_ready", req0_ready, 0);
      step();
    end
    rsp1_ready = 1;
    #1 chk("bp_release_accept", req0_ready, 1);
    step();
    req0_valid = 0;
    step();
    chk("bp_next_result", rsp_result, 2);
    step();

    // Unused opcode 15.
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_ctrl = 4'hF;
    step();
    req0_valid = 0;
    step();
    chk("op15_result", rsp_result, 0);
    chk("op15_zero", rsp_zero, 1);
    step();

    // Asynchronous reset during EXEC.
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_ctrl = 0;
    step();
    req0_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsp0_valid", rsp0_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_alu_a", alu_a, 0);
    reset_model();
    #1 rst_n = 1'b1;
    repeat (3) step();
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_ctrl = 0;
    req1_valid = 1; req1_a = 5; req1_b = 5; req1_ctrl = 0;
    #1 chk("arst_first_grant", req0_ready, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    step();

    // Back-to-back on req0: XOR then OR.
    rsp0_ready = 1;
    req0_valid = 1; req0_a = 32'hFF; req0_b = 32'h0F; req0_ctrl = 4;
    step();
    req0_a = 32'hF0; req0_b = 32'h0F; req0_ctrl = 3;
    #1 chk("b2b_exec_ready", req0_ready, 0);
    step();
    chk("b2b_xor", rsp_result, 32'hF0);
    chk("b2b_accept", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("b2b_exec_gap", rsp0_valid, 0);
    step();
    chk("b2b_or", rsp_result, 32'hFF);
    step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (g0 || !req0_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          req0_valid = 1; req0_a = rnd_val(); req0_b = rnd_val();
          req0_ctrl = 4'($urandom_range(0, 15));
        end else req0_valid = 0;
      end
      if (g1 || !req1_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          req1_valid = 1; req1_a = rnd_val(); req1_b = rnd_val();
          req1_ctrl = 4'($urandom_range(0, 15));
        end else req1_valid = 0;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance (a, b, alu_ctrl in; result, zero out) between two requesters, e.g. the EX stage and a branch/address helper.
- Round-robin arbitration over valid/ready request channels.
- Operands are registered and the ALU output is captured.
- The result returns on the winner's valid/ready response channel.
- The ALU itself sits outside this block; the block only sequences and steers it.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 4, ALU opcode width (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; others yield result 0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand a
req0_b  input  WIDTH  operand b
req0_ctrl  input  CTRL_W  ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  as requester 0
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result for requester 1 available
rsp1_ready  input  1  requester 1 takes result
rsp_result  output  WIDTH  captured ALU result (shared by both response channels)
rsp_zero  output  1  captured ALU zero flag
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_ctrl  output  CTRL_W  to ALU opcode
alu_result  input  WIDTH  from ALU result
alu_zero  input  1  from ALU zero
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking: one clock (clk). Reset rst_n is asynchronous and active-low. All state is in flops cleared by rst_n low, released synchronously to clk.
- Reset values:
  - state IDLE; last_grant = 1, so requester 0 wins the first contention.
  - Operand regs 0, so alu_a = alu_b = 0 and alu_ctrl = 0.
  - rsp0_valid = rsp1_valid = 0, rsp_result = 0, rsp_zero = 0, busy = 0.
  - req*_ready = 0 while no valid is present.
- States: IDLE, EXEC, RESP.
- Accept window: state IDLE, or state RESP with the current response handshaking this cycle (rspN_valid & rspN_ready).
- Grant (combinational, only in the accept window):
  - One valid: grant it.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = grant_N. At most one ready is high per cycle. Ready never asserts without the matching valid.
- On accept (valid & ready at the edge):
  - Capture a/b/ctrl into operand regs and the owner id.
  - last_grant <= owner; state -> EXEC.
- EXEC (one cycle):
  - alu_a/alu_b/alu_ctrl are driven from the operand regs.
  - At the edge: rsp_result <= alu_result, rsp_zero <= alu_zero, owner's rspN_valid <= 1, state -> RESP.
- RESP:
  - rsp_result/rsp_zero and the owner's rspN_valid are held stable until rspN_ready.
  - The non-owner's rsp valid stays 0.
  - Handshake with no new accept -> IDLE, rspN_valid cleared.
  - Handshake with a same-cycle accept -> EXEC for the new operation.
- Latency: accept at edge k -> rspN_valid high after edge k+1. With rsp_ready tied high, throughput is one operation per 2 cycles.
- Operand regs change only on accept. alu_* outputs are stable from EXEC through RESP.
- Opcode pass-through: opcodes 10..15 are passed through unchanged; the ALU returns 0, so zero = 1. No error is flagged.
- Request stability: a request held valid and not granted must keep its operands stable. The arbiter samples only at accept.
- Response backpressure: rspN_ready low in RESP stalls indefinitely. No new request is accepted, and both req*_ready stay 0.
- Reset asserted mid-EXEC or mid-RESP:
  - The outstanding operation is dropped and no response is issued.
  - All outputs immediately take their reset values. last_grant returns to 1.
- Round-robin is strict alternation under continuous contention. A lone requester may win repeatedly.

Test Plan:
- Reset, then req0 ADD a=5 b=7 with rsp0_ready=1 -> req0_ready at cycle 0; rsp0_valid one cycle later with rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
- Both valid at once: req0 SUB 9,9 and req1 SLTU 1,2, held -> req0 granted first (result 0, zero=1), then req1 (result 1); alternation continues over 6 back-to-back operations.
- req1 SRA a=0x80000000 b=4 with rsp1_ready low for 5 cycles -> rsp1_valid and rsp_result=0xF8000000 held stable; busy=1; req0_valid high the whole time gets no ready; after rsp1_ready, req0 is accepted the same cycle.
- Opcode 4'b1111, a=3 b=4 -> rsp_result=0, rsp_zero=1, normal handshake.
- rst_n pulsed low during EXEC -> rsp0_valid/rsp1_valid never assert for that operation; all outputs zero asynchronously; next contention grants req0.
- Back-to-back: req0 always valid and rsp0_ready=1, XOR 0xFF/0x0F then OR 0xF0/0x0F -> results 0xF0 and 0xFF, one result every 2 cycles.
